// File: rtl/fpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fpu_pkg                                                |
// | Description : Shared encodings for the FPU issue block: operation    |
// |               codes, issue-FSM state type and the canonical NaN.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fpu_pkg;

  localparam logic [1:0] FPU_OP_ADD  = 2'b00;
  localparam logic [1:0] FPU_OP_SUB  = 2'b01;
  localparam logic [1:0] FPU_OP_MUL  = 2'b10;
  localparam logic [1:0] FPU_OP_RSVD = 2'b11;

  localparam logic [31:0] FPU_CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } fpu_state_t;

  // Reserved encodings never reach the FPU; they complete with an error.
  function automatic logic fpu_op_is_rsvd(input logic [1:0] op);
    return (op == FPU_OP_RSVD);
  endfunction

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fpu_watchdog                                           |
// | Description : Cycle counter with synchronous clear and count enable. |
// |               o_expire flags the enabled cycle that is the LIMIT-th  |
// |               counted cycle since the last clear.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fpu_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,       // asynchronous, active-low
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int               c_cw   = $clog2(LIMIT + 1);
  localparam logic [c_cw-1:0]  c_last = c_cw'(LIMIT - 1);

  logic [c_cw-1:0] r_count;

  // Count enabled cycles; clear has priority so a fresh wait starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != c_last)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The current enabled cycle is the LIMIT-th one when LIMIT-1 have been seen.
  assign o_expire = i_en && (r_count == c_last);

endmodule : fpu_watchdog
`default_nettype wire

// File: rtl/fpu_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fpu_issue                                              |
// | Description : Start/done initiator between the execute stage and the |
// |               FPU. Accepts one op, pulses start, waits for done and  |
// |               presents a single-cycle writeback. Stalls while busy.  |
// |               Optional WAIT watchdog enabled by FPU_TIMEOUT_EN.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active-low
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  input  logic [4:0]  i_req_rd,
  output logic        o_stall,
  output logic        o_fpu_start,
  output logic [1:0]  o_fpu_op,
  output logic [31:0] o_fpu_a,
  output logic [31:0] o_fpu_b,
  input  logic        i_fpu_done,
  input  logic [31:0] i_fpu_r,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_wb_err
);

  fpu_state_t  r_state;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_rd;
  logic [31:0] r_data;
  logic        r_err;
  logic        w_expire;

  // Elaboration-time sanity check on the watchdog limit.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fpu_issue: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef FPU_TIMEOUT_EN
  logic w_wd_clear;
  logic w_wd_en;

  // Counter restarts as WAIT is entered (ISSUE always precedes WAIT) and
  // only counts WAIT cycles in which done is still low.
  assign w_wd_clear = (r_state == ST_ISSUE);
  assign w_wd_en    = (r_state == ST_WAIT) && !i_fpu_done;

  fpu_watchdog #(
    .LIMIT    (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_wd_clear),
    .i_en     (w_wd_en),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // Issue FSM: latch on acceptance, wait for done, hold captured result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_op    <= FPU_OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_rd    <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_op <= i_req_op;
            r_a  <= i_req_a;
            r_b  <= i_req_b;
            r_rd <= i_req_rd;
            if (fpu_op_is_rsvd(i_req_op)) begin
              r_data  <= FPU_CANON_NAN;
              r_err   <= 1'b1;
              r_state <= ST_WB;
            end else begin
              r_err   <= 1'b0;
              r_state <= ST_ISSUE;
            end
          end
        end
        // Done is deliberately not looked at here: a level-held done from
        // the previous op must not complete this one.
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        // Done beats an expiry in the same cycle.
        ST_WAIT: begin
          if (i_fpu_done) begin
            r_data  <= i_fpu_r;
            r_err   <= 1'b0;
            r_state <= ST_WB;
          end else if (w_expire) begin
            r_data  <= FPU_CANON_NAN;
            r_err   <= 1'b1;
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake and strobe outputs decode the state register only.
  assign o_req_ready = (r_state == ST_IDLE);
  assign o_stall     = (r_state != ST_IDLE);
  assign o_fpu_start = (r_state == ST_ISSUE);
  assign o_wb_valid  = (r_state == ST_WB);

  assign o_fpu_op  = r_op;
  assign o_fpu_a   = r_a;
  assign o_fpu_b   = r_b;
  assign o_wb_rd   = r_rd;
  assign o_wb_data = r_data;
  assign o_wb_err  = r_err;

endmodule : fpu_issue
`default_nettype wire
